// File: rtl/trail_stack_if.sv
// Handshake bundle between the trail stack and its clients: push port from
// propagation/decision logic, backtrack request, and the undo stream.
interface trail_stack_if #(
  parameter int VAR_W    = 32,
  parameter int LVL_W    = 16,
  parameter int REASON_W = 16
);
  logic                push_valid;
  logic                push_ready;
  logic [VAR_W-1:0]    push_var;
  logic                push_value;
  logic [LVL_W-1:0]    push_level;
  logic                push_is_dec;
  logic [REASON_W-1:0] push_reason;

  logic                bt_req;
  logic                bt_ready;
  logic [LVL_W-1:0]    bt_level;
  logic                bt_done;

  logic                undo_valid;
  logic                undo_ready;
  logic [VAR_W-1:0]    undo_var;
  logic                undo_value;
  logic [LVL_W-1:0]    undo_level;
  logic                undo_is_dec;

  modport master (
    output push_valid, push_var, push_value, push_level, push_is_dec, push_reason,
    output bt_req, bt_level, undo_ready,
    input  push_ready, bt_ready, bt_done,
    input  undo_valid, undo_var, undo_value, undo_level, undo_is_dec
  );

  modport slave (
    input  push_valid, push_var, push_value, push_level, push_is_dec, push_reason,
    input  bt_req, bt_level, undo_ready,
    output push_ready, bt_ready, bt_done,
    output undo_valid, undo_var, undo_value, undo_level, undo_is_dec
  );
endinterface

// File: rtl/trail_stack.sv
// Assignment trail held as a LIFO with a multi-cycle backtrack engine that
// streams every entry above the target level out through the undo port.
module trail_stack #(
  parameter int  DEPTH    = 64,
  parameter int  VAR_W    = 32,
  parameter int  LVL_W    = 16,
  parameter int  REASON_W = 16,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  trail_stack_if.slave     tif,
  output logic [CNT_W-1:0] count,
  output logic [LVL_W-1:0] top_level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             order_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [VAR_W-1:0]    var_id;
    logic                value;
    logic [LVL_W-1:0]    level;
    logic                is_dec;
    logic [REASON_W-1:0] reason;
  } entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BT   = 1'b1
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [LVL_W-1:0]   tgt_r;
  logic               overflow_r;
  logic               order_err_r;
  entry_t             mem_r [DEPTH];

  logic               full_s;
  logic               empty_s;
  logic [IDX_W-1:0]   top_idx_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [VAR_W-1:0]   top_var_s;
  logic               top_value_s;
  logic [LVL_W-1:0]   top_lvl_s;
  logic               top_dec_s;
  logic               cond_s;
  logic               push_ready_s;
  logic               bt_ready_s;
  logic               undo_valid_s;
  logic               bt_done_s;
  logic               push_fire_s;
  logic               bt_fire_s;
  logic               pop_fire_s;
  logic               overflow_set_s;
  logic               order_set_s;
  entry_t             push_entry_s;

  // Occupancy flags, top-of-stack read and handshake decode.
  always_comb begin
    full_s      = (count_r == CNT_FULL);
    empty_s     = (count_r == {CNT_W{1'b0}});
    wr_idx_s    = IDX_W'(count_r);
    if (empty_s) begin
      top_idx_s = {IDX_W{1'b0}};
    end else begin
      top_idx_s = IDX_W'(count_r - CNT_ONE);
    end
    top_var_s   = mem_r[top_idx_s].var_id;
    top_value_s = mem_r[top_idx_s].value;
    top_lvl_s   = mem_r[top_idx_s].level;
    top_dec_s   = mem_r[top_idx_s].is_dec;

    // An empty trail reads as level 0 so nothing is ever popped from it.
    cond_s       = ~empty_s & (top_lvl_s > tgt_r);
    bt_ready_s   = (state_r == IDLE);
    push_ready_s = (state_r == IDLE) & ~full_s & ~tif.bt_req;
    undo_valid_s = (state_r == BT) & cond_s;
    bt_done_s    = (state_r == BT) & ~cond_s;

    push_fire_s    = tif.push_valid & push_ready_s;
    bt_fire_s      = tif.bt_req & bt_ready_s;
    pop_fire_s     = undo_valid_s & tif.undo_ready;
    overflow_set_s = (state_r == IDLE) & tif.push_valid & full_s;
    order_set_s    = push_fire_s & ~empty_s & (tif.push_level < top_lvl_s);

    push_entry_s.var_id = tif.push_var;
    push_entry_s.value  = tif.push_value;
    push_entry_s.level  = tif.push_level;
    push_entry_s.is_dec = tif.push_is_dec;
    push_entry_s.reason = tif.push_reason;
  end

  // Trail storage; contents are left as-is across reset.
  always_ff @(posedge clk) begin
    if (!rst && push_fire_s) begin
      mem_r[wr_idx_s] <= push_entry_s;
    end
  end

  // Control FSM: pushes and backtrack capture in IDLE, pop stream in BT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= {CNT_W{1'b0}};
      tgt_r       <= {LVL_W{1'b0}};
      overflow_r  <= 1'b0;
      order_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (push_fire_s) begin
            count_r <= count_r + CNT_ONE;
          end
          if (overflow_set_s) begin
            overflow_r <= 1'b1;
          end
          if (order_set_s) begin
            order_err_r <= 1'b1;
          end
          if (bt_fire_s) begin
            tgt_r   <= tif.bt_level;
            state_r <= BT;
          end
        end
        BT: begin
          if (bt_done_s) begin
            state_r <= IDLE;
          end else if (pop_fire_s) begin
            count_r <= count_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tif.push_ready  = push_ready_s;
  assign tif.bt_ready    = bt_ready_s;
  assign tif.bt_done     = bt_done_s;
  assign tif.undo_valid  = undo_valid_s;
  assign tif.undo_var    = top_var_s;
  assign tif.undo_value  = top_value_s;
  assign tif.undo_level  = top_lvl_s;
  assign tif.undo_is_dec = top_dec_s;

  assign count     = count_r;
  assign top_level = empty_s ? {LVL_W{1'b0}} : top_lvl_s;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign order_err = order_err_r;

endmodule

// File: tb/tb_trail_stack.sv
// Self-checking bench for trail_stack: directed scenarios plus randomized
// push/backtrack traffic compared against a queue-based trail model.
module tb_trail_stack;

  localparam int DEPTH    = 64;
  localparam int VAR_W    = 32;
  localparam int LVL_W    = 16;
  localparam int REASON_W = 16;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trail_stack_if #(.VAR_W(VAR_W), .LVL_W(LVL_W), .REASON_W(REASON_W)) tif ();

  logic [CNT_W-1:0] count;
  logic [LVL_W-1:0] top_level;
  logic             empty, full, overflow, order_err;

  trail_stack #(.DEPTH(DEPTH), .VAR_W(VAR_W), .LVL_W(LVL_W), .REASON_W(REASON_W)) dut (
    .clk(clk), .rst(rst), .tif(tif), .count(count), .top_level(top_level),
    .empty(empty), .full(full), .overflow(overflow), .order_err(order_err)
  );

  typedef struct {
    logic [VAR_W-1:0] v;
    logic             val;
    logic [LVL_W-1:0] lvl;
    logic             dec;
  } ent_t;

  ent_t model_q[$];
  bit   ovf_m, oerr_m;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [LVL_W-1:0] model_top();
    if (model_q.size() == 0) return '0;
    return model_q[model_q.size()-1].lvl;
  endfunction

  task automatic idle_inputs();
    tif.push_valid = 1'b0; tif.push_var = '0; tif.push_value = 1'b0;
    tif.push_level = '0; tif.push_is_dec = 1'b0; tif.push_reason = '0;
    tif.bt_req = 1'b0; tif.bt_level = '0; tif.undo_ready = 1'b0;
  endtask

  task automatic do_push(input logic [VAR_W-1:0] v, input logic val, input logic [LVL_W-1:0] lvl,
                         input logic dec, input logic [REASON_W-1:0] rsn);
    logic exp_ready;
    tif.push_valid = 1'b1; tif.push_var = v; tif.push_value = val;
    tif.push_level = lvl; tif.push_is_dec = dec; tif.push_reason = rsn;
    #1;
    exp_ready = (model_q.size() < DEPTH);
    checks++;
    if (tif.push_ready !== exp_ready) begin
      errors++; $display("FAIL push_ready: got %b expected %b", tif.push_ready, exp_ready);
    end
    @(posedge clk); #1;
    tif.push_valid = 1'b0;
    if (exp_ready) begin
      if (model_q.size() > 0 && lvl < model_top()) oerr_m = 1'b1;
      model_q.push_back('{v: v, val: val, lvl: lvl, dec: dec});
    end else begin
      ovf_m = 1'b1;
    end
    checks++;
    if ({count, top_level, empty, full, overflow, order_err} !==
        {CNT_W'(model_q.size()), model_top(), model_q.size() == 0, model_q.size() == DEPTH, ovf_m, oerr_m}) begin
      errors++;
      $display("FAIL push_state: got cnt=%0d top=%0d emp=%b full=%b ovf=%b oerr=%b expected cnt=%0d top=%0d ovf=%b oerr=%b",
               count, top_level, empty, full, overflow, order_err, model_q.size(), model_top(), ovf_m, oerr_m);
    end
  endtask

  // Issues a backtrack, consumes the undo stream and checks beats, order and latency.
  task automatic run_backtrack(input logic [LVL_W-1:0] lvl, input int stall, input bit rnd);
    ent_t exp_q[$];
    int   beats, cyc, exp_cyc;
    bit   done;
    tif.bt_req = 1'b1; tif.bt_level = lvl;
    #1;
    checks++;
    if (tif.bt_ready !== 1'b1) begin
      errors++; $display("FAIL bt_ready: got %b expected 1", tif.bt_ready);
    end
    @(posedge clk); #1;
    tif.bt_req = 1'b0;
    while (model_q.size() > 0 && model_top() > lvl) exp_q.push_back(model_q.pop_back());
    beats = 0; done = 1'b0; cyc = 1;
    while (!done && cyc <= 4 * DEPTH + 16) begin
      tif.undo_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc > stall);
      #1;
      checks++;
      if (tif.push_ready !== 1'b0 || tif.bt_ready !== 1'b0) begin
        errors++; $display("FAIL bt_busy_ready: got push_ready=%b bt_ready=%b expected 0/0", tif.push_ready, tif.bt_ready);
      end
      if (tif.undo_valid === 1'b1) begin
        checks++;
        if (beats >= exp_q.size()) begin
          errors++; $display("FAIL undo_extra: got var %0h, expected no further beat", tif.undo_var);
        end else if ({tif.undo_var, tif.undo_value, tif.undo_level, tif.undo_is_dec} !==
                     {exp_q[beats].v, exp_q[beats].val, exp_q[beats].lvl, exp_q[beats].dec}) begin
          errors++;
          $display("FAIL undo_entry: got var=%0h val=%b lvl=%0d dec=%b expected var=%0h val=%b lvl=%0d dec=%b",
                   tif.undo_var, tif.undo_value, tif.undo_level, tif.undo_is_dec,
                   exp_q[beats].v, exp_q[beats].val, exp_q[beats].lvl, exp_q[beats].dec);
        end
        if (tif.bt_done === 1'b1) begin
          errors++; $display("FAIL done_with_valid: got bt_done=1 expected 0");
        end
        if (tif.undo_ready) beats++;
      end else if (tif.bt_done === 1'b1) begin
        done = 1'b1;
        checks++;
        if (beats != exp_q.size()) begin
          errors++; $display("FAIL undo_beats: got %0d expected %0d", beats, exp_q.size());
        end
        if (!rnd) begin
          exp_cyc = exp_q.size() + 1 + ((exp_q.size() > 0) ? stall : 0);
          checks++;
          if (cyc != exp_cyc) begin
            errors++; $display("FAIL bt_latency: got %0d expected %0d", cyc, exp_cyc);
          end
        end
      end else begin
        checks++; errors++;
        $display("FAIL bt_stuck: got undo_valid=0 bt_done=0 expected one of them at cycle %0d", cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    tif.undo_ready = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL bt_timeout: got no bt_done expected one within %0d cycles", 4 * DEPTH + 16);
    end
    #1;
    checks++;
    if ({tif.bt_done, tif.bt_ready, tif.undo_valid, count, top_level} !==
        {1'b0, 1'b1, 1'b0, CNT_W'(model_q.size()), model_top()}) begin
      errors++;
      $display("FAIL bt_after: got done=%b rdy=%b uv=%b cnt=%0d top=%0d expected 0 1 0 cnt=%0d top=%0d",
               tif.bt_done, tif.bt_ready, tif.undo_valid, count, top_level, model_q.size(), model_top());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_q.delete(); ovf_m = 1'b0; oerr_m = 1'b0;
    #1;
    checks++;
    if ({count, top_level, empty, full, overflow, order_err} !== {CNT_W'(0), LVL_W'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_status: got cnt=%0d top=%0d emp=%b full=%b ovf=%b oerr=%b expected 0 0 1 0 0 0",
                         count, top_level, empty, full, overflow, order_err);
    end
    checks++;
    if ({tif.push_ready, tif.bt_ready, tif.undo_valid, tif.bt_done} !== 4'b1100) begin
      errors++; $display("FAIL reset_handshake: got %b expected 1100",
                         {tif.push_ready, tif.bt_ready, tif.undo_valid, tif.bt_done});
    end
  endtask

  task automatic test_push_basic();
    do_push(32'd5, 1'b1, 16'd0, 1'b0, 16'd0);
    do_push(32'd9, 1'b0, 16'd1, 1'b1, 16'd0);
    do_push(32'd12, 1'b1, 16'd1, 1'b0, 16'd7);
    do_push(32'd3, 1'b1, 16'd2, 1'b1, 16'd0);
  endtask

  task automatic test_backtrack();
    run_backtrack(16'd0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_push(32'd9, 1'b0, 16'd1, 1'b1, 16'd0);
    do_push(32'd12, 1'b1, 16'd1, 1'b0, 16'd7);
    do_push(32'd3, 1'b1, 16'd2, 1'b1, 16'd0);
    run_backtrack(16'd1, 3, 1'b0);
  endtask

  task automatic test_simultaneous();
    tif.push_valid = 1'b1; tif.push_var = 32'd20; tif.push_value = 1'b0;
    tif.push_level = 16'd1; tif.push_is_dec = 1'b1; tif.push_reason = 16'd0;
    tif.bt_req = 1'b1; tif.bt_level = 16'd0;
    #1;
    checks++;
    if ({tif.push_ready, tif.bt_ready} !== 2'b01) begin
      errors++; $display("FAIL simul_priority: got push_ready=%b bt_ready=%b expected 0 1", tif.push_ready, tif.bt_ready);
    end
    run_backtrack(16'd0, 0, 1'b0);
    checks++;
    if (tif.push_ready !== 1'b1) begin
      errors++; $display("FAIL simul_push_resume: got push_ready=%b expected 1", tif.push_ready);
    end
    @(posedge clk); #1;
    tif.push_valid = 1'b0;
    model_q.push_back('{v: 32'd20, val: 1'b0, lvl: 16'd1, dec: 1'b1});
    checks++;
    if ({count, top_level} !== {CNT_W'(model_q.size()), model_top()}) begin
      errors++; $display("FAIL simul_push_done: got cnt=%0d top=%0d expected cnt=%0d top=%0d",
                         count, top_level, model_q.size(), model_top());
    end
  endtask

  task automatic test_fill_overflow();
    int i = 0;
    while (model_q.size() < DEPTH) begin
      do_push($urandom, 1'($urandom_range(0, 1)), LVL_W'(1 + i / 8), (i % 8) == 0, 16'($urandom));
      i++;
    end
    do_push(32'hDEAD, 1'b1, 16'd50, 1'b1, 16'd0);
    run_backtrack(16'hFFFF, 0, 1'b0);
    run_backtrack(16'd0, 0, 1'b0);
  endtask

  task automatic test_order_and_reset();
    do_push(32'd40, 1'b1, 16'd3, 1'b1, 16'd0);
    do_push(32'd41, 1'b0, 16'd2, 1'b0, 16'd4);
    tif.bt_req = 1'b1; tif.bt_level = 16'd0; tif.undo_ready = 1'b0;
    @(posedge clk); #1;
    tif.bt_req = 1'b0;
    checks++;
    if ({tif.undo_valid, tif.undo_var} !== {1'b1, 32'd41}) begin
      errors++; $display("FAIL rst_pre_undo: got valid=%b var=%0d expected 1 41", tif.undo_valid, tif.undo_var);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete(); ovf_m = 1'b0; oerr_m = 1'b0;
    checks++;
    if ({count, tif.undo_valid, overflow, order_err, tif.bt_done, tif.bt_ready, empty} !==
        {CNT_W'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rst_midbt: got cnt=%0d uv=%b ovf=%b oerr=%b done=%b rdy=%b emp=%b expected 0 0 0 0 0 1 1",
                         count, tif.undo_valid, overflow, order_err, tif.bt_done, tif.bt_ready, empty);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tif.bt_done !== 1'b0) begin
        errors++; $display("FAIL rst_no_done: got bt_done=%b expected 0", tif.bt_done);
      end
    end
  endtask

  task automatic test_random();
    logic [LVL_W-1:0] lvl;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0 || model_q.size() >= DEPTH) begin
        run_backtrack(LVL_W'($urandom_range(0, int'(model_top()))), 0, 1'b1);
      end else begin
        lvl = model_top() + LVL_W'($urandom_range(0, 1));
        if (model_top() > 0 && $urandom_range(0, 11) == 0) lvl = model_top() - LVL_W'(1);
        do_push($urandom, 1'($urandom_range(0, 1)), lvl, 1'($urandom_range(0, 1)), 16'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_backtrack();
    test_backpressure();
    test_simultaneous();
    test_fill_overflow();
    test_order_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
